// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte write to rx_data, byte read from tx_data. Optional I2C_SLAVE_GLITCH_FILTER_EN.
// Latency: pin edge -> event 3 clk (5 with filter); sda_oe moves 4 clk after SCL fall (6 with filter).
// Backpressure: none; the host must present tx_data within half an SCL period of tx_req.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_s3_q;
    logic sda_s1_q, sda_s2_q, sda_s3_q;
    logic scl_line, sda_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // Registered 3-sample majority: a level must persist 2 clk to pass.
    logic scl_h1_q, scl_h2_q, scl_f_q;
    logic sda_h1_q, sda_h2_q, sda_f_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_h1_q <= 1'b1;
            scl_h2_q <= 1'b1;
            scl_f_q  <= 1'b1;
            sda_h1_q <= 1'b1;
            sda_h2_q <= 1'b1;
            sda_f_q  <= 1'b1;
        end else begin
            scl_h1_q <= scl_s2_q;
            scl_h2_q <= scl_h1_q;
            scl_f_q  <= (scl_s2_q & scl_h1_q) | (scl_s2_q & scl_h2_q) | (scl_h1_q & scl_h2_q);
            sda_h1_q <= sda_s2_q;
            sda_h2_q <= sda_h1_q;
            sda_f_q  <= (sda_s2_q & sda_h1_q) | (sda_s2_q & sda_h2_q) | (sda_h1_q & sda_h2_q);
        end
    end

    assign scl_line = scl_f_q;
    assign sda_line = sda_f_q;
`else
    assign scl_line = scl_s2_q;
    assign sda_line = sda_s2_q;
`endif

    logic scl_rise_q, scl_fall_q, start_q, stop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s3_q   <= 1'b1;
            sda_s3_q   <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_s3_q   <= scl_line;
            sda_s3_q   <= sda_line;
            scl_rise_q <= scl_line & ~scl_s3_q;
            scl_fall_q <= ~scl_line & scl_s3_q;
            start_q    <= scl_line & scl_s3_q & ~sda_line & sda_s3_q;
            stop_q     <= scl_line & scl_s3_q & sda_line & ~sda_s3_q;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            rw_q       <= rw_d;
            mack_q     <= mack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        rw_d       = rw_q;
        mack_d     = mack_q;

        if (stop_q) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_q) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
        end else begin
            case (state_q)
                ADDR, WR_DATA: begin
                    // sda_s3_q is the SDA level aligned with the registered SCL rise.
                    if (scl_rise_q && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s3_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_q && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == WR_DATA) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = WR_ACK;
                        end else if (shift_q[7:1] == SLAVE_ADDR) begin
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise_q && rw_q) begin
                        tx_req_d = 1'b1;
                    end else if (scl_fall_q) begin
                        if (rw_q) begin
                            tx_shift_d = {tx_data[6:0], 1'b0};
                            sda_oe_d   = ~tx_data[7];
                            bit_cnt_d  = 4'd1;
                            state_d    = RD_DATA;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            shift_d   = 8'h00;
                            state_d   = WR_DATA;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall_q) begin
                        sda_oe_d = 1'b0;
                        shift_d  = 8'h00;
                        state_d  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall_q) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_ACK;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise_q) begin
                        mack_d   = sda_s3_q;
                        tx_req_d = ~sda_s3_q;
                    end else if (scl_fall_q) begin
                        if (!mack_q) begin
                            tx_shift_d = {tx_data[6:0], 1'b0};
                            sda_oe_d   = ~tx_data[7];
                            bit_cnt_d  = 4'd1;
                            state_d    = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = (state_q == ADDR_ACK) || (state_q == WR_DATA) || (state_q == WR_ACK) ||
                      (state_q == RD_DATA)  || (state_q == RD_ACK);

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: open-drain bus model, table of write transfers, hand sequences for corner cases.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       scl_i, sda_i, sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
    );

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int   LAT         = 6;
    localparam logic GLITCH_BUSY = 1'b1;
`else
    localparam int   LAT         = 4;
    localparam logic GLITCH_BUSY = 1'b0;
`endif

    int rx_cnt = 0, tx_cnt = 0, oe_cnt = 0, busy_cnt = 0, bad_cnt = 0;
    logic oe_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_cnt++;
        if (tx_req === 1'b1) tx_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (sda_oe !== oe_prev && scl_i === 1'b1) bad_cnt++;
        oe_prev = sda_oe;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cond();
        tick(10); sda_m = 1'b1;
        tick(10); scl_m = 1'b1;
        tick(10); sda_m = 1'b0;
        tick(10); scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        tick(10); sda_m = 1'b0;
        tick(10); scl_m = 1'b1;
        tick(10); sda_m = 1'b1;
        tick(20);
    endtask

    // Entered and left with SCL low; returns the bus level seen mid-high.
    task automatic send_bit(input logic b, output logic s);
        tick(10); sda_m = b;
        tick(10); scl_m = 1'b1;
        tick(10); s = sda_i;
        tick(10); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(1'b1, b[i]);
        tx_data = next_tx;
        send_bit(~mack, s);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_rx_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       a1, a2, s;
        logic [7:0] b1, b2;
        int         rx0, tx0, oe0, busy0;
        logic [7:0] a0_byte;

        vecs[0] = '{8'hA0, 8'hA5, 1'b1, 8'hA5};
        vecs[1] = '{8'hA2, 8'h5A, 1'b0, 8'hA5};
        vecs[2] = '{8'hA0, 8'h00, 1'b1, 8'h00};
        vecs[3] = '{8'hA0, 8'hFF, 1'b1, 8'hFF};
        vecs[4] = '{8'h20, 8'h12, 1'b0, 8'hFF};

        tick(5);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick(20);

        for (int v = 0; v < 5; v++) begin
            rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
            start_cond();
            send_byte(vecs[v].addr_byte, a1);
            send_byte(vecs[v].data, a2);
            stop_cond();
            chk($sformatf("v%0d_addr_ack", v), a1, vecs[v].exp_ack);
            chk($sformatf("v%0d_data_ack", v), a2, vecs[v].exp_ack);
            chk($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx_data);
            chk($sformatf("v%0d_rx_pulses", v), rx_cnt - rx0, vecs[v].exp_ack ? 1 : 0);
            chk($sformatf("v%0d_oe_seen", v), (oe_cnt - oe0) > 0, vecs[v].exp_ack);
            chk($sformatf("v%0d_busy_seen", v), (busy_cnt - busy0) > 0, vecs[v].exp_ack);
            chk($sformatf("v%0d_tx_req", v), tx_cnt - tx0, 0);
            chk($sformatf("v%0d_idle_busy", v), busy, 0);
        end

        // Read two bytes, master ACKs the first and NACKs the second.
        tx_data = 8'h3C;
        tx0 = tx_cnt;
        start_cond();
        send_byte(8'hA1, a1);
        chk("rd_addr_ack", a1, 1);
        read_byte(1'b1, 8'hC3, b1);
        read_byte(1'b0, 8'h00, b2);
        chk("rd_byte0", b1, 8'h3C);
        chk("rd_byte1", b2, 8'hC3);
        chk("rd_tx_req", tx_cnt - tx0, 2);
        tick(10);
        chk("rd_nack_oe", sda_oe, 0);
        chk("rd_nack_busy", busy, 0);
        stop_cond();

        // STOP after 4 data bits, then a normal write.
        rx0 = rx_cnt;
        start_cond();
        send_byte(8'hA0, a1);
        for (int i = 0; i < 4; i++) send_bit(i[0], s);
        stop_cond();
        chk("abort_rx_pulses", rx_cnt - rx0, 0);
        chk("abort_oe", sda_oe, 0);
        chk("abort_busy", busy, 0);
        start_cond();
        send_byte(8'hA0, a1);
        send_byte(8'h5C, a2);
        stop_cond();
        chk("after_abort_ack", {a1, a2}, 2'b11);
        chk("after_abort_rx", rx_data, 8'h5C);
        chk("after_abort_pulses", rx_cnt - rx0, 1);

        // Reset while driving read bit 3 low, then repeated START with latency check.
        tx_data = 8'h00;
        start_cond();
        send_byte(8'hA1, a1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        tick(8);
        chk("rst_pre_oe", sda_oe, 1);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_oe", sda_oe, 0);
        rst = 1'b0;
        tick(5);
        chk("rst_mid_busy", busy, 0);
        start_cond();
        a0_byte = 8'hA0;
        for (int i = 7; i >= 0; i--) send_bit(a0_byte[i], s);
        tick(LAT - 1);
        chk("ack_lat_before", sda_oe, 0);
        tick(1);
        chk("ack_lat_at", sda_oe, 1);
        send_bit(1'b1, s);
        chk("restart_ack", s, 0);
        send_byte(8'h11, a2);
        stop_cond();
        chk("restart_rx", rx_data, 8'h11);

        // 1-clk SDA low glitch with SCL high during a write data bit.
        start_cond();
        send_byte(8'hA0, a1);
        tick(10); sda_m = 1'b1;
        tick(10); scl_m = 1'b1;
        tick(10); sda_m = 1'b0;
        tick(1);  sda_m = 1'b1;
        tick(12);
        chk("glitch_busy", busy, GLITCH_BUSY);
        tick(5); scl_m = 1'b0;
        stop_cond();
        chk("glitch_end_busy", busy, 0);

        chk("oe_change_scl_high", bad_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
